sync_fifo_flags: RTL and testbench

- Parametrised single-clock FIFO built around an occupancy counter; successor to the team's basic counter-based synchronous FIFO.
- Adds programmable almost-full/almost-empty thresholds, an exported fill level, sticky overflow/underflow error flags with clear, and an optional first-word-fall-through (FWFT) read mode.
- Intended as the standard buffering element between producer/consumer stages in one clock domain.

---
 rtl/sync_fifo_flags.sv | 166 ++++++++++++++++
 tb/tb_sync_fifo_flags.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flags
// Purpose  : Single-clock, occupancy-counter FIFO with programmable
//            almost-full / almost-empty thresholds, exported fill level,
//            sticky overflow / underflow flags with clear, and an optional
//            first-word-fall-through read port.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     r_en,
  input  logic                     clr_err,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  // --------------------------------------------------------------------------
  // Derived widths and width-matched constants
  // --------------------------------------------------------------------------
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]         C_DEPTH   = CW'(DEPTH);
  localparam logic [CW-1:0]         C_AF      = CW'(AF_THRESH);
  localparam logic [CW-1:0]         C_AE      = CW'(AE_THRESH);
  localparam logic [CW-1:0]         C_CNT_ONE = CW'(1);
  localparam logic [AW-1:0]         C_PTR_ONE = AW'(1);
  localparam logic [DATA_WIDTH-1:0] C_ZERO    = '0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_wr_reject;
  logic                  w_rd_reject;
  logic [DATA_WIDTH-1:0] w_head;

  // --------------------------------------------------------------------------
  // Status decodes: everything is derived from the registered count, so the
  // flags move in the cycle after the edge that accepted the operation.
  // --------------------------------------------------------------------------
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is dropped even if a read pops in the same
  // cycle; a read from an empty FIFO is refused even if a write lands in
  // the same cycle (no bypass path from data_in to data_out).
  assign w_wr_accept = w_en & ~w_full;
  assign w_rd_accept = r_en & ~w_empty;
  assign w_wr_reject = w_en &  w_full;
  assign w_rd_reject = r_en &  w_empty;

  assign w_head = r_mem[r_rd_ptr];

  // Storage array: written on accepted writes only, intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_accept) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Write pointer: natural power-of-two wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (w_wr_accept) begin
      r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
    end
  end

  // Read pointer: natural power-of-two wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (w_rd_accept) begin
      r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  // Occupancy counter: a concurrent accepted push and pop cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      unique case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  & ~clr_err) | w_wr_reject;
      r_underflow <= (r_underflow & ~clr_err) | w_rd_reject;
    end
  end

  // --------------------------------------------------------------------------
  // Read data path
  // --------------------------------------------------------------------------
  generate
    if (FWFT) begin : g_fwft
      // Head word is presented as soon as it exists; r_en acknowledges it.
      assign data_out = w_empty ? C_ZERO : w_head;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_data_out;

      // Registered read: capture the head word on an accepted read, hold
      // otherwise (including on refused reads).
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data_out <= '0;
        end else if (w_rd_accept) begin
          r_data_out <= w_head;
        end
      end

      assign data_out = r_data_out;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_flags
// Purpose  : Directed, table-driven bench for sync_fifo_flags. One instance
//            in registered-read mode (DEPTH=8, AF=6, AE=2) driven from a
//            vector table, a second in FWFT mode exercised by hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flags;

  localparam int DW = 8;
  localparam int DP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read instance signals
  logic          rst0, w_en0, r_en0, clr0;
  logic [DW-1:0] din0, dout0;
  logic          full0, empty0, af0, ae0, ovf0, udf0;
  logic [3:0]    cnt0;

  // FWFT instance signals
  logic          rst1, w_en1, r_en1, clr1;
  logic [DW-1:0] din1, dout1;
  logic          full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0]    cnt1;

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)
  ) u_std (
    .clk(clk), .rst(rst0), .w_en(w_en0), .data_in(din0), .r_en(r_en0),
    .clr_err(clr0), .data_out(dout0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)
  ) u_fwft (
    .clk(clk), .rst(rst1), .w_en(w_en1), .data_in(din1), .r_en(r_en1),
    .clr_err(clr1), .data_out(dout1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(udf1)
  );

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic          c;
    logic [DW-1:0] e_dout;
    logic [3:0]    e_cnt;
    logic          e_ovf;
    logic          e_udf;
  } vec_t;

  vec_t vecs [200];
  int   n_vec   = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  function automatic void add(input logic w, input logic [DW-1:0] d,
                              input logic r, input logic c,
                              input logic [DW-1:0] e_dout,
                              input int e_cnt, input logic e_ovf,
                              input logic e_udf);
    vecs[n_vec].w      = w;
    vecs[n_vec].d      = d;
    vecs[n_vec].r      = r;
    vecs[n_vec].c      = c;
    vecs[n_vec].e_dout = e_dout;
    vecs[n_vec].e_cnt  = 4'(e_cnt);
    vecs[n_vec].e_ovf  = e_ovf;
    vecs[n_vec].e_udf  = e_udf;
    n_vec++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every output of the registered-read instance against a count
  // plus the flag thresholds of this configuration (full=8, AF>=6, AE<=2).
  task automatic chk_std(input string tag, input logic [DW-1:0] e_dout,
                         input int e_cnt, input logic e_ovf,
                         input logic e_udf);
    chk({tag, " dout"},  32'(dout0), 32'(e_dout));
    chk({tag, " count"}, 32'(cnt0),  32'(e_cnt));
    chk({tag, " full"},  32'(full0), 32'(e_cnt == 8));
    chk({tag, " empty"}, 32'(empty0), 32'(e_cnt == 0));
    chk({tag, " af"},    32'(af0),   32'(e_cnt >= 6));
    chk({tag, " ae"},    32'(ae0),   32'(e_cnt <= 2));
    chk({tag, " ovf"},   32'(ovf0),  32'(e_ovf));
    chk({tag, " udf"},   32'(udf0),  32'(e_udf));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case anything stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] last;
    logic [DW-1:0] nxt;
    int            q;

    rst0 = 1'b1; w_en0 = 1'b0; r_en0 = 1'b0; clr0 = 1'b0; din0 = '0;
    rst1 = 1'b1; w_en1 = 1'b0; r_en1 = 1'b0; clr1 = 1'b0; din1 = '0;

    // ---------------- vector table --------------------------------------
    // Fill 0x10..0x17, count 1..8
    for (int k = 1; k <= 8; k++) add(1, DW'(8'h0F + k), 0, 0, 8'h00, k, 0, 0);
    // Ninth write while full: dropped, overflow set
    add(1, 8'h99, 0, 0, 8'h00, 8, 1, 0);
    // Drain 0x10..0x17
    for (int k = 1; k <= 8; k++) add(0, 8'h00, 1, 0, DW'(8'h0F + k), 8 - k, 1, 0);
    // Extra read: refused, underflow set, data held
    add(0, 8'h00, 1, 0, 8'h17, 0, 1, 1);
    // Clear both errors
    add(0, 8'h00, 0, 1, 8'h17, 0, 0, 0);
    // Wrap-around: three rounds of write 5 / read 5
    last = 8'h17;
    nxt  = 8'h00;
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 1; k <= 5; k++) add(1, nxt + DW'(k - 1), 0, 0, last, k, 0, 0);
      for (int k = 1; k <= 5; k++) add(0, 8'h00, 1, 0, nxt + DW'(k - 1), 5 - k, 0, 0);
      last = nxt + 8'd4;
      nxt  = nxt + 8'd5;
    end
    // Simultaneous at count=4
    for (int k = 0; k < 4; k++) add(1, DW'(8'h40 + k), 0, 0, 8'h0E, k + 1, 0, 0);
    for (int k = 0; k < 3; k++) add(1, DW'(8'h44 + k), 1, 0, DW'(8'h40 + k), 4, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 8'h00, 1, 0, DW'(8'h43 + k), 3 - k, 0, 0);
    // Simultaneous at full: pop wins, write dropped
    for (int k = 0; k < 8; k++) add(1, DW'(8'h50 + k), 0, 0, 8'h46, k + 1, 0, 0);
    add(1, 8'hEE, 1, 0, 8'h50, 7, 1, 0);
    add(0, 8'h00, 0, 1, 8'h50, 7, 0, 0);
    for (int k = 1; k <= 7; k++) add(0, 8'h00, 1, 0, DW'(8'h50 + k), 7 - k, 0, 0);
    // Simultaneous at empty: write lands, read refused
    add(1, 8'h60, 1, 0, 8'h57, 1, 0, 1);
    add(0, 8'h00, 0, 1, 8'h57, 1, 0, 0);
    add(0, 8'h00, 1, 0, 8'h60, 0, 0, 0);
    // Clear and new underflow in the same cycle: set wins
    add(0, 8'h00, 1, 1, 8'h60, 0, 0, 1);
    add(0, 8'h00, 0, 1, 8'h60, 0, 0, 0);

    // ---------------- reset ---------------------------------------------
    step();
    step();
    rst0 = 1'b0;
    rst1 = 1'b0;
    chk_std("reset", 8'h00, 0, 0, 0);

    // ---------------- apply table ---------------------------------------
    for (int i = 0; i < n_vec; i++) begin
      w_en0 = vecs[i].w;
      din0  = vecs[i].d;
      r_en0 = vecs[i].r;
      clr0  = vecs[i].c;
      step();
      chk_std($sformatf("v%0d", i), vecs[i].e_dout, int'(vecs[i].e_cnt),
              vecs[i].e_ovf, vecs[i].e_udf);
    end
    w_en0 = 1'b0; r_en0 = 1'b0; clr0 = 1'b0;

    // ---------------- reset mid-operation -------------------------------
    for (int k = 0; k < 5; k++) begin
      w_en0 = 1'b1; din0 = DW'(8'h70 + k);
      step();
    end
    w_en0 = 1'b0; r_en0 = 1'b1;
    step();
    r_en0 = 1'b0; w_en0 = 1'b1; din0 = 8'h75;
    step();
    w_en0 = 1'b0;
    chk_std("pre_rst", 8'h70, 5, 0, 0);
    rst0 = 1'b1; w_en0 = 1'b1; din0 = 8'hFF;
    step();
    rst0 = 1'b0; w_en0 = 1'b0;
    chk_std("mid_rst", 8'h00, 0, 0, 0);
    w_en0 = 1'b1; din0 = 8'hA1;
    step();
    din0 = 8'hA2;
    step();
    w_en0 = 1'b0; r_en0 = 1'b1;
    step();
    r_en0 = 1'b0;
    chk_std("post_rst_rd", 8'hA1, 1, 0, 0);

    // ---------------- FWFT instance -------------------------------------
    chk("fwft reset dout",  32'(dout1),  32'h00);
    chk("fwft reset empty", 32'(empty1), 32'h1);
    w_en1 = 1'b1; din1 = 8'hA5;
    step();
    w_en1 = 1'b0;
    chk("fwft fall dout",  32'(dout1), 32'hA5);
    chk("fwft fall count", 32'(cnt1),  32'h1);
    step();
    chk("fwft hold dout",  32'(dout1), 32'hA5);
    r_en1 = 1'b1;
    step();
    r_en1 = 1'b0;
    chk("fwft pop empty", 32'(empty1), 32'h1);
    chk("fwft pop dout",  32'(dout1),  32'h00);
    chk("fwft pop udf",   32'(udf1),   32'h0);
    w_en1 = 1'b1; din1 = 8'hB1;
    step();
    din1 = 8'hB2;
    step();
    w_en1 = 1'b0;
    chk("fwft head1", 32'(dout1), 32'hB1);
    r_en1 = 1'b1;
    step();
    chk("fwft head2", 32'(dout1), 32'hB2);
    step();
    q = 0;
    r_en1 = 1'b1;
    step();
    r_en1 = 1'b0;
    chk("fwft udf",       32'(udf1),  32'h1);
    chk("fwft udf dout",  32'(dout1), 32'h00);
    chk("fwft udf count", 32'(cnt1),  32'(q));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_check, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
